// File: rtl/dispatch_core_nq_pkg.sv
// Shared decode constants, queue map and holding-register state
// for the dispatch stage.
package dispatch_core_nq_pkg;

    localparam int QW = 3;

    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    localparam logic [QW-1:0] Q_DEFAULT = 3'd0;
    localparam logic [QW-1:0] Q_LDST    = 3'd1;
    localparam logic [QW-1:0] Q_MULT    = 3'd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    function automatic logic [QW-1:0] op_to_q(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic [QW-1:0] q;
        q = Q_DEFAULT;
        case (op)
            OP_LW, OP_SW: q = Q_LDST;
            OP_RTYPE:
                if (fn == FN_MULT || fn == FN_MULTU)
                    q = Q_MULT;
            default: q = Q_DEFAULT;
        endcase
        return q;
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/dispatch_core_nq_if.sv
// Fetch, tag, issue-queue and stall-counter signals of the
// dispatch stage; slave is the dispatch core's view.
interface dispatch_core_nq_if #(
    parameter int NQ    = 3,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
);
    logic [31:0]         ifetch_pc_4;
    logic [31:0]         ifetch_instruction;
    logic                ifetch_empty;
    logic                Dispatch_ren;
    logic                Dispatch_jmp;
    logic [31:0]         Dispatch_jmp_addr;
    logic [TAG_W-1:0]    tag_in;
    logic                tag_valid;
    logic                tag_ren;
    logic                rob_full;
    logic [NQ-1:0]       issueque_full;
    logic [NQ-1:0]       dispatch_en;
    logic [31:0]         dispatch_instr;
    logic [31:0]         dispatch_pc_4;
    logic [TAG_W-1:0]    dispatch_rd_tag;
    logic                stall_clr;
    logic [NQ*CNT_W-1:0] stall_cnt;

    modport slave (
        input  ifetch_pc_4, ifetch_instruction, ifetch_empty,
        input  tag_in, tag_valid, rob_full, issueque_full,
        input  stall_clr,
        output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        output tag_ren, dispatch_en, dispatch_instr,
        output dispatch_pc_4, dispatch_rd_tag, stall_cnt
    );

    modport master (
        output ifetch_pc_4, ifetch_instruction, ifetch_empty,
        output tag_in, tag_valid, rob_full, issueque_full,
        output stall_clr,
        input  Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        input  tag_ren, dispatch_en, dispatch_instr,
        input  dispatch_pc_4, dispatch_rd_tag, stall_cnt
    );
endinterface

// File: rtl/dispatch_class_decoder.sv
// Maps an instruction word to its issue-queue index and jump flag;
// indices beyond the configured queue count fall back to queue 0.
module dispatch_class_decoder
    import dispatch_core_nq_pkg::*;
#(
    parameter int NQ = 3
) (
    input  logic [31:0]   i_instr,
    output logic [QW-1:0] o_q,
    output logic          o_jmp
);
    logic [QW-1:0] w_q;
    logic          w_unused;

    assign w_q      = op_to_q(i_instr[31:26], i_instr[5:0]);
    assign o_q      = (32'(w_q) >= NQ) ? Q_DEFAULT : w_q;
    assign o_jmp    = is_jump(i_instr[31:26]);
    assign w_unused = ^i_instr[25:6];
endmodule

// File: rtl/dispatch_core_nq.sv
// Single-entry dispatch holding register: steers the held instruction
// to its issue queue or resolves jumps, and counts per-queue stalls.
module dispatch_core_nq
    import dispatch_core_nq_pkg::*;
#(
    parameter int NQ    = 3,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    dispatch_core_nq_if.slave  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic [QW-1:0]    r_q;
    logic             r_jmp;
    logic [CNT_W-1:0] r_cnt [NQ];

    logic [QW-1:0]    w_dq;
    logic             w_djmp;
    logic             w_held;
    logic             w_qfull;
    logic             w_fire;
    logic             w_jfire;
    logic             w_ren;

    dispatch_class_decoder #(.NQ(NQ)) u_dec (
        .i_instr (bus.ifetch_instruction),
        .o_q     (w_dq),
        .o_jmp   (w_djmp)
    );

    // Full flag of the queue selected by the held instruction
    always_comb begin
        w_qfull = 1'b0;
        for (int i = 0; i < NQ; i++)
            if (r_q == QW'(i))
                w_qfull = bus.issueque_full[i];
    end

    assign w_held  = (r_state == ST_HELD) && !reset;
    assign w_jfire = w_held && r_jmp;
    assign w_fire  = w_held && !r_jmp && !w_qfull &&
                     bus.tag_valid && !bus.rob_full;

    // Next state and IFQ read: refill on fire, never on a jump
    always_comb begin
        w_next = r_state;
        w_ren  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_EMPTY: begin
                    w_ren = !bus.ifetch_empty;
                    if (w_ren)
                        w_next = ST_HELD;
                end
                ST_HELD: begin
                    if (w_jfire) begin
                        w_next = ST_EMPTY;
                    end else if (w_fire) begin
                        w_ren  = !bus.ifetch_empty;
                        w_next = w_ren ? ST_HELD : ST_EMPTY;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_next;
    end

    // Holding register captures the IFQ head on every read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr <= '0;
            r_pc4   <= '0;
            r_q     <= '0;
            r_jmp   <= 1'b0;
        end else if (w_ren) begin
            r_instr <= bus.ifetch_instruction;
            r_pc4   <= bus.ifetch_pc_4;
            r_q     <= w_dq;
            r_jmp   <= w_djmp;
        end
    end

    // Saturating stall counters; clear wins over increment
    always_ff @(posedge clock) begin
        if (reset || bus.stall_clr) begin
            for (int i = 0; i < NQ; i++)
                r_cnt[i] <= '0;
        end else if (w_held && !w_jfire && !w_fire) begin
            for (int i = 0; i < NQ; i++)
                if (r_q == QW'(i) && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
    end

    // One-hot queue write enable and packed counter view
    always_comb begin
        bus.dispatch_en = '0;
        bus.stall_cnt   = '0;
        for (int i = 0; i < NQ; i++) begin
            bus.dispatch_en[i] = w_fire && (r_q == QW'(i));
            bus.stall_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign bus.tag_ren           = w_fire;
    assign bus.Dispatch_ren      = w_ren;
    assign bus.Dispatch_jmp      = w_jfire;
    assign bus.Dispatch_jmp_addr = {r_pc4[31:28], r_instr[25:0], 2'b00};
    assign bus.dispatch_instr    = r_instr;
    assign bus.dispatch_pc_4     = r_pc4;
    assign bus.dispatch_rd_tag   = w_fire ? bus.tag_in : '0;
endmodule
